// File: rtl/rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq_pkg
// Description : Shared types, default timing constants and parameter checks
//               for the staged reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package rst_seq_pkg;

    // Sequencer states; encoding is fixed so it can be observed in debug
    typedef enum logic [1:0] {
        RESET   = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    // Default timing constants used as parameter defaults
    localparam int c_def_num_ch      = 4;
    localparam int c_def_hold_cycles = 5;
    localparam int c_def_stage_gap   = 2;
    localparam int c_def_cnt_w       = 8;
    localparam int c_def_sync_stages = 2;
    localparam int c_def_wdog_limit  = 1000;
    localparam int c_def_wdog_w      = 16;

    // True when a cnt_w-bit counter can reach the last release point
    function automatic bit cnt_w_fits(input int cnt_w, input int hold,
                                      input int nch, input int gap);
        longint l_need;
        longint l_cap;
        l_need = longint'(hold) + longint'(nch - 1) * longint'(gap);
        l_cap  = longint'(1) << cnt_w;
        return (l_need < l_cap);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rst_sync.sv
`default_nettype none
// ============================================================================
// Module      : rst_sync
// Description : Reset synchroniser. Asserts asynchronously with rst and
//               deasserts synchronously after SYNC_STAGES clk edges.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_sync
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = c_def_sync_stages
) (
    input  logic clk,
    input  logic rst,
    output logic o_rst_sync
);

    logic [SYNC_STAGES-1:0] r_chain;

    // Flop chain: set immediately by rst, shifts zeros in once rst is gone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '1;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign o_rst_sync = r_chain[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/rst_seq_gen.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq_gen
// Description : Staged reset sequencer. Holds NUM_CH reset outputs for
//               HOLD_CYCLES, then releases them STAGE_GAP cycles apart, bit 0
//               first. Supports a soft-reset request/ack handshake.
//               Optional watchdog built when RST_SEQ_WDOG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module rst_seq_gen
    import rst_seq_pkg::*;
#(
    parameter int NUM_CH      = c_def_num_ch,
    parameter int HOLD_CYCLES = c_def_hold_cycles,
    parameter int STAGE_GAP   = c_def_stage_gap,
    parameter int CNT_W       = c_def_cnt_w,
    parameter int SYNC_STAGES = c_def_sync_stages,
    parameter int WDOG_LIMIT  = c_def_wdog_limit,
    parameter int WDOG_W      = c_def_wdog_w
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              soft_rst_req,
    output logic              soft_rst_ack,
    input  logic              wdog_kick,
    output logic [NUM_CH-1:0] rst_out,
    output logic              all_released,
    output logic              busy,
    output logic              wdog_fired
);

    // Counter value sampled on the edge that releases bit 0 / the last bit
    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_last      =
        CNT_W'(HOLD_CYCLES - 1 + (NUM_CH - 1) * STAGE_GAP);

    if (!cnt_w_fits(CNT_W, HOLD_CYCLES, NUM_CH, STAGE_GAP)) begin : g_cnt_w_check
        $error("rst_seq_gen: CNT_W too small for HOLD_CYCLES/NUM_CH/STAGE_GAP");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [NUM_CH-1:0] r_rst_out;
    logic [NUM_CH-1:0] w_rst_out_nxt;
    logic [NUM_CH-1:0] w_clr_mask;
    logic              r_ack;
    logic              w_ack_nxt;
    logic              r_req_d;
    logic              w_req_rise;
    logic              w_wdog_expire;
    logic              w_restart;
    logic              w_rst_i;

    rst_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk        (clk),
        .rst        (rst),
        .o_rst_sync (w_rst_i)
    );

    // Channel i is released on the edge where the counter reads its slot
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_clr
        localparam int c_rel_at = HOLD_CYCLES - 1 + gi * STAGE_GAP;
        assign w_clr_mask[gi] = (r_cnt == CNT_W'(c_rel_at));
    end

    assign w_req_rise = soft_rst_req & ~r_req_d;
    assign w_restart  = (r_state != RESET) && (w_req_rise || w_wdog_expire);

    // Next-state, counter and reset-output logic; restart overrides all
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_rst_out_nxt = r_rst_out;
        w_ack_nxt     = 1'b0;
        case (r_state)
            RESET: begin
                if (!w_rst_i) begin
                    w_state_nxt = ASSERT;
                    w_cnt_nxt   = '0;
                end
            end
            ASSERT: begin
                // A held request freezes the hold period at its start
                if (soft_rst_req) begin
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == c_hold_last) begin
                        w_rst_out_nxt = r_rst_out & ~w_clr_mask;
                        w_state_nxt   = (r_cnt == c_last) ? RUN : RELEASE;
                    end
                end
            end
            RELEASE: begin
                w_cnt_nxt     = r_cnt + CNT_W'(1);
                w_rst_out_nxt = r_rst_out & ~w_clr_mask;
                if (r_cnt == c_last) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = RESET;
            end
        endcase
        if (w_restart) begin
            w_state_nxt   = ASSERT;
            w_cnt_nxt     = '0;
            w_rst_out_nxt = '1;
            w_ack_nxt     = w_req_rise;
        end
    end

    // Sequencer registers; rst forces every output to its reset value at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= RESET;
            r_cnt     <= '0;
            r_rst_out <= '1;
            r_ack     <= 1'b0;
            r_req_d   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rst_out <= w_rst_out_nxt;
            r_ack     <= w_ack_nxt;
            r_req_d   <= soft_rst_req;
        end
    end

`ifdef RST_SEQ_WDOG_EN
    logic [WDOG_W-1:0] r_wdog_cnt;
    logic              r_wdog_fired;

    // A soft request on the same edge takes priority over the watchdog
    assign w_wdog_expire = (r_state == RUN) && !wdog_kick && !w_req_rise &&
                           (r_wdog_cnt == WDOG_W'(WDOG_LIMIT - 1));

    // Watchdog counter runs only in RUN; sticky flag records any expiry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog_cnt   <= '0;
            r_wdog_fired <= 1'b0;
        end else begin
            if ((r_state == RUN) && !wdog_kick && !w_restart) begin
                r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
            end else begin
                r_wdog_cnt <= '0;
            end
            if (w_wdog_expire) begin
                r_wdog_fired <= 1'b1;
            end
        end
    end

    assign wdog_fired = r_wdog_fired;
`else
    logic w_unused;

    assign w_wdog_expire = 1'b0;
    assign wdog_fired    = 1'b0;
    assign w_unused      = &{1'b0, wdog_kick, WDOG_W'(WDOG_LIMIT)};
`endif

    assign rst_out      = r_rst_out;
    assign all_released = ~|r_rst_out;
    assign busy         = (r_state != RUN);
    assign soft_rst_ack = r_ack;

endmodule
`default_nettype wire
